// File: rtl/conv_pkg.sv
// Shared types and width helpers for the streaming
// convolution/correlation engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        HOLD,
        DONE
    } state_e;

    typedef enum logic {
        CONV,
        CORR
    } mode_e;

    function automatic int calc_ow(input int len, input int dw);
        return 2 * dw + $clog2(len + 1);
    endfunction

    function automatic int calc_lw(input int len);
        return $clog2(2 * len - 1);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate unit with a registered
// accumulator; clear restarts the sum for a new lag.
module conv_mac
    import conv_pkg::*;
#(
    parameter int DW     = 1,
    parameter int OW     = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          enable_i,
    input  logic [DW-1:0] op_a_i,
    input  logic [DW-1:0] op_b_i,
    output logic [OW-1:0] acc_o
);

    localparam int PW = 2 * DW;

    logic [PW-1:0] prod;
    logic [OW-1:0] prod_ext;
    logic [OW-1:0] acc_q;
    logic [OW-1:0] acc_d;

    // Product at 2*DW bits, extended per operand signedness
    always_comb begin
        prod     = '0;
        prod_ext = '0;
        if (SIGNED) begin
            prod = $signed({{DW{op_a_i[DW-1]}}, op_a_i})
                 * $signed({{DW{op_b_i[DW-1]}}, op_b_i});
            prod_ext = {{(OW-PW){prod[PW-1]}}, prod};
        end else begin
            prod = {{DW{1'b0}}, op_a_i} * {{DW{1'b0}}, op_b_i};
            prod_ext = {{(OW-PW){1'b0}}, prod};
        end
    end

    // Next accumulator value: first product of a lag replaces the sum
    always_comb begin
        acc_d = acc_q;
        if (enable_i) begin
            acc_d = (clear_i ? '0 : acc_q) + prod_ext;
        end else if (clear_i) begin
            acc_d = '0;
        end
    end

    // Accumulator register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/conv_stream_engine.sv
// Time-multiplexed 1-D convolution/correlation engine that
// streams every lag result over a valid/ready handshake.
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter  int LEN    = 6,
    parameter  int DW     = 1,
    parameter  bit SIGNED = 1'b0,
    localparam int OW     = calc_ow(LEN, DW),
    localparam int LW     = calc_lw(LEN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [LEN*DW-1:0] a_in,
    input  logic [LEN*DW-1:0] b_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_data,
    output logic [LW-1:0]     out_lag,
    output logic              out_last,
    output logic              done
);

    localparam int          IW   = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [LW-1:0] LAST = LW'(2 * LEN - 2);
    localparam logic [LW-1:0] MID  = LW'(LEN - 1);

    state_e        state_q, state_d;
    mode_e         mode_q;
    logic [LW-1:0] lag_q, lag_d;
    logic [LW-1:0] pair_q, pair_d;
    logic [DW-1:0] a_q [LEN];
    logic [DW-1:0] b_q [LEN];
    logic          latch;
    logic          mac_en;
    logic          mac_clr;
    logic [LW-1:0] n_last;
    logic [LW-1:0] i_lo;
    logic [LW-1:0] idx_a;
    logic [LW-1:0] idx_b;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [OW-1:0] acc;

    // Pair count of the current lag and operand indices for both modes
    always_comb begin
        n_last = (lag_q < MID) ? lag_q : LAST - lag_q;
        i_lo   = '0;
        idx_a  = '0;
        idx_b  = '0;
        if (mode_q == CONV) begin
            i_lo  = (lag_q > MID) ? lag_q - MID : '0;
            idx_a = i_lo + pair_q;
            idx_b = lag_q - idx_a;
        end else begin
            i_lo  = (lag_q < MID) ? MID - lag_q : '0;
            idx_a = i_lo + pair_q;
            idx_b = idx_a + lag_q - MID;
        end
    end

    assign op_a = a_q[idx_a[IW-1:0]];
    assign op_b = b_q[idx_b[IW-1:0]];

    // Next-state and counter control
    always_comb begin
        state_d = state_q;
        lag_d   = lag_q;
        pair_d  = pair_q;
        latch   = 1'b0;
        mac_en  = 1'b0;
        mac_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                latch   = 1'b1;
                lag_d   = '0;
                pair_d  = '0;
                state_d = MAC;
            end
            MAC: begin
                mac_en  = 1'b1;
                mac_clr = (pair_q == '0);
                if (pair_q == n_last) begin
                    pair_d  = '0;
                    state_d = HOLD;
                end else begin
                    pair_d = pair_q + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (lag_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        lag_d   = lag_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lag_q   <= '0;
            pair_q  <= '0;
        end else begin
            state_q <= state_d;
            lag_q   <= lag_d;
            pair_q  <= pair_d;
        end
    end

    // Operand and mode capture, frozen for the rest of the run
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q <= CONV;
            for (int e = 0; e < LEN; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
            end
        end else if (latch) begin
            mode_q <= mode_e'(mode);
            for (int e = 0; e < LEN; e++) begin
                a_q[e] <= a_in[e*DW +: DW];
                b_q[e] <= b_in[e*DW +: DW];
            end
        end
    end

    conv_mac #(
        .DW     (DW),
        .OW     (OW),
        .SIGNED (SIGNED)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (mac_clr),
        .enable_i (mac_en),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .acc_o    (acc)
    );

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign out_data  = acc;
    assign out_lag   = lag_q;
    assign out_last  = (state_q == HOLD) && (lag_q == LAST);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_conv_stream_engine.sv
// Self-checking bench: default engine (LEN=6, DW=1) plus a
// signed LEN=3, DW=4 engine, checked against a direct-sum model.
module tb_conv_stream_engine;

    logic clk;
    logic rst_n;

    logic        start1, mode1, out_ready1;
    logic [5:0]  a_in1, b_in1;
    logic        busy1, out_valid1, out_last1, done1;
    logic [4:0]  out_data1;
    logic [3:0]  out_lag1;

    logic        start2, mode2, out_ready2;
    logic [11:0] a_in2, b_in2;
    logic        busy2, out_valid2, out_last2, done2;
    logic [9:0]  out_data2;
    logic [2:0]  out_lag2;

    int n_checks;
    int n_fail;
    logic [4:0] got1 [11];
    logic [9:0] got2 [5];
    int last_done_cyc;

    conv_stream_engine u_dut1 (
        .clock     (clk),
        .reset     (rst_n),
        .start     (start1),
        .mode      (mode1),
        .a_in      (a_in1),
        .b_in      (b_in1),
        .busy      (busy1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_data  (out_data1),
        .out_lag   (out_lag1),
        .out_last  (out_last1),
        .done      (done1)
    );

    conv_stream_engine #(
        .LEN    (3),
        .DW     (4),
        .SIGNED (1'b1)
    ) u_dut2 (
        .clock     (clk),
        .reset     (rst_n),
        .start     (start2),
        .mode      (mode2),
        .a_in      (a_in2),
        .b_in      (b_in2),
        .busy      (busy2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_lag   (out_lag2),
        .out_last  (out_last2),
        .done      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // y[k] straight from the definitions, over all index pairs
    function automatic int ref1(input bit md, input logic [5:0] av,
                                input logic [5:0] bv, input int k);
        int s;
        s = 0;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                if ((!md && i + j == k) || (md && j == i + k - 5))
                    s += int'(av[i]) * int'(bv[j]);
        return s;
    endfunction

    function automatic int ref2(input bit md, input logic [11:0] av,
                                input logic [11:0] bv, input int k);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if ((!md && i + j == k) || (md && j == i + k - 2))
                    s += int'($signed(av[i*4 +: 4])) * int'($signed(bv[j*4 +: 4]));
        return s;
    endfunction

    function automatic int nk(input int k);
        return ((k < 10 - k) ? k : 10 - k) + 1;
    endfunction

    task automatic run1(input bit md, input logic [5:0] av, input logic [5:0] bv,
                        input int stall_lag, input int stall_n,
                        input bit rnd, input bit disturb);
        int cyc, nres, hs_cyc, stall_cnt, exp_v;
        bit pend, rdy;
        logic [4:0] pd;
        logic [3:0] pl;
        logic plast;
        @(negedge clk);
        a_in1 = av; b_in1 = bv; mode1 = md; start1 = 1'b1; out_ready1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 1; nres = 0; hs_cyc = 1; stall_cnt = 0; pend = 1'b0;
        last_done_cyc = -1;
        pd = '0; pl = '0; plast = 1'b0;
        while (cyc < 2000) begin
            if (disturb && cyc == 4) begin
                start1 = 1'b1; a_in1 = ~av; b_in1 = 6'($urandom); mode1 = ~md;
            end else if (disturb && cyc == 5) begin
                start1 = 1'b0;
            end
            if (done1 === 1'b1) begin
                last_done_cyc = cyc;
                break;
            end
            n_checks++;
            if (busy1 !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_run cyc=%0d got=%b want=1", cyc, busy1);
            end
            if (pend) begin
                n_checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== pd ||
                    out_lag1 !== pl || out_last1 !== plast) begin
                    n_fail++;
                    $display("FAIL hold_stable cyc=%0d got v=%b d=%0d l=%0d want v=1 d=%0d l=%0d",
                             cyc, out_valid1, out_data1, out_lag1, pd, pl);
                end
            end else if (out_valid1 === 1'b1) begin
                exp_v = ref1(md, av, bv, nres);
                n_checks += 4;
                if (out_lag1 !== 4'(nres)) begin
                    n_fail++;
                    $display("FAIL lag_order got=%0d want=%0d", out_lag1, nres);
                end
                if (cyc != hs_cyc + nk(nres) + 1) begin
                    n_fail++;
                    $display("FAIL lag_latency k=%0d got=%0d want=%0d",
                             nres, cyc - hs_cyc, nk(nres) + 1);
                end
                if (out_data1 !== 5'(exp_v)) begin
                    n_fail++;
                    $display("FAIL data k=%0d got=%0d want=%0d", nres, out_data1, exp_v);
                end
                if (out_last1 !== (nres == 10)) begin
                    n_fail++;
                    $display("FAIL last k=%0d got=%b want=%b", nres, out_last1, nres == 10);
                end
                if (nres < 11) got1[nres] = out_data1;
            end
            rdy = 1'b1;
            if (nres == stall_lag && stall_cnt < stall_n) begin
                rdy = 1'b0;
                if (out_valid1 === 1'b1) stall_cnt++;
            end else if (rnd) begin
                rdy = 1'($urandom_range(0, 1));
            end
            out_ready1 = rdy;
            if (out_valid1 === 1'b1 && rdy) begin
                nres++; hs_cyc = cyc; pend = 1'b0;
            end else if (out_valid1 === 1'b1) begin
                pend = 1'b1; pd = out_data1; pl = out_lag1; plast = out_last1;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready1 = 1'b0;
        start1 = 1'b0;
        n_checks += 3;
        if (last_done_cyc < 0) begin
            n_fail++;
            $display("FAIL done_timeout got=none want=pulse");
        end else if (last_done_cyc != hs_cyc + 1) begin
            n_fail++;
            $display("FAIL done_after_last got=%0d want=%0d", last_done_cyc, hs_cyc + 1);
        end
        if (nres != 11) begin
            n_fail++;
            $display("FAIL result_count got=%0d want=11", nres);
        end
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_done got=%b want=1", busy1);
        end
        if (stall_n == 0 && !rnd) begin
            n_checks++;
            if (last_done_cyc != 49) begin
                n_fail++;
                $display("FAIL run_length got=%0d want=49", last_done_cyc);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || out_valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done got done=%b busy=%b valid=%b want 0 0 0",
                     done1, busy1, out_valid1);
        end
    endtask

    task automatic run2(input bit md, input logic [11:0] av, input logic [11:0] bv);
        int n, cyc, exp_v;
        bit seen_done;
        @(negedge clk);
        a_in2 = av; b_in2 = bv; mode2 = md; start2 = 1'b1; out_ready2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0; seen_done = 1'b0;
        for (cyc = 1; cyc < 200 && !seen_done; cyc++) begin
            if (done2 === 1'b1) begin
                seen_done = 1'b1;
            end else if (out_valid2 === 1'b1) begin
                exp_v = ref2(md, av, bv, n);
                n_checks += 3;
                if (out_lag2 !== 3'(n)) begin
                    n_fail++;
                    $display("FAIL s_lag got=%0d want=%0d", out_lag2, n);
                end
                if (out_data2 !== 10'(exp_v)) begin
                    n_fail++;
                    $display("FAIL s_data k=%0d got=%0d want=%0d",
                             n, $signed(out_data2), exp_v);
                end
                if (out_last2 !== (n == 4)) begin
                    n_fail++;
                    $display("FAIL s_last k=%0d got=%b", n, out_last2);
                end
                if (n < 5) got2[n] = out_data2;
                n++;
            end
            if (!seen_done) @(negedge clk);
        end
        n_checks++;
        if (!seen_done || n != 5) begin
            n_fail++;
            $display("FAIL s_run got results=%0d done=%b want 5 1", n, seen_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start1 = 0; mode1 = 0; out_ready1 = 0; a_in1 = '0; b_in1 = '0;
        start2 = 0; mode2 = 0; out_ready2 = 0; a_in2 = '0; b_in2 = '0;
        #1;
        n_checks++;
        if ({busy1, out_valid1, out_data1, out_lag1, out_last1, done1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0",
                     {busy1, out_valid1, out_data1, out_lag1, out_last1, done1});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy1, out_valid1, done1, busy2, done2} !== '0) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%b want=0",
                     {busy1, out_valid1, done1, busy2, done2});
        end
    endtask

    task automatic test_corr_plan;
        run1(1'b1, 6'b110110, 6'b110110, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (got1[5] !== 5'd4) begin
            n_fail++;
            $display("FAIL corr_lag5 got=%0d want=4", got1[5]);
        end
    endtask

    task automatic test_conv_plan;
        int exp_tab [11] = '{0, 0, 1, 2, 1, 2, 4, 2, 1, 2, 1};
        run1(1'b0, 6'b110110, 6'b110110, -1, 0, 1'b0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            n_checks++;
            if (got1[k] !== 5'(exp_tab[k])) begin
                n_fail++;
                $display("FAIL conv_seq k=%0d got=%0d want=%0d", k, got1[k], exp_tab[k]);
            end
        end
    endtask

    task automatic test_backpressure;
        run1(1'b0, 6'b101101, 6'b011111, 3, 5, 1'b0, 1'b0);
        run1(1'b1, 6'b111011, 6'b110101, 3, 5, 1'b0, 1'b0);
    endtask

    task automatic test_disturb;
        run1(1'b0, 6'b011011, 6'b111001, -1, 0, 1'b0, 1'b1);
        run1(1'b1, 6'b100111, 6'b101110, -1, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++)
            run1(1'($urandom), 6'($urandom), 6'($urandom), -1, 0, 1'($urandom), 1'b0);
    endtask

    task automatic test_signed;
        int exp_tab [5] = '{-2, 5, 3, -1, 3};
        run2(1'b0, 12'h32F, 12'h1F2);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (got2[k] !== 10'(exp_tab[k])) begin
                n_fail++;
                $display("FAIL signed_plan k=%0d got=%h want=%h", k, got2[k], 10'(exp_tab[k]));
            end
        end
        for (int r = 0; r < 4; r++)
            run2(1'($urandom), 12'($urandom), 12'($urandom));
    endtask

    task automatic test_reset_midrun;
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        a_in1 = 6'b111111; b_in1 = 6'b111111; mode1 = 1'b0;
        start1 = 1'b1; out_ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (out_lag1 === 4'd4 && out_valid1 === 1'b0 && busy1 === 1'b1) hit = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reach_lag4 got=timeout want=lag4_mac");
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy1, out_valid1, out_data1, out_lag1, out_last1, done1} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=0",
                     {busy1, out_valid1, out_data1, out_lag1, out_last1, done1});
        end
        out_ready1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run1(1'b1, 6'b110110, 6'b011101, -1, 0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset;
        test_corr_plan;
        test_conv_plan;
        test_backpressure;
        test_disturb;
        test_random;
        test_signed;
        test_reset_midrun;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
